// File: rtl/field_sequencer_pkg.sv
// Shared types and constant helpers for field_sequencer: field geometry
// (offsets/widths) and enable-mask scanning.
package field_sequencer_pkg;

    localparam int unsigned MAX_FIELDS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned FW_W       = 16;

    // One width entry per field slot; entry 0 is field 0.
    typedef logic [MAX_FIELDS-1:0][FW_W-1:0] widths_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } next_t;

    // Bit offset of field n: sum of all lower field widths.
    function automatic int unsigned field_offset(input int unsigned n, input widths_t widths);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < MAX_FIELDS; i++) begin
            if (i < n) off += 32'(widths[i]);
        end
        return off;
    endfunction

    function automatic int unsigned width_of(input int unsigned n, input widths_t widths);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < MAX_FIELDS; i++) begin
            if (i == n) w = 32'(widths[i]);
        end
        return w;
    endfunction

    // Last active field absorbs whatever input bits remain; unused slots are zeroed.
    function automatic widths_t resolve_widths(input widths_t raw, input int unsigned in_width,
                                               input int unsigned num_fields);
        widths_t w;
        w = '0;
        for (int unsigned i = 0; i < MAX_FIELDS; i++) begin
            if (i + 1 < num_fields)       w[i] = raw[i];
            else if (i + 1 == num_fields) w[i] = FW_W'(in_width - field_offset(i, raw));
        end
        return w;
    endfunction

    // Lowest set bit strictly above 'from'.
    function automatic next_t next_set(input logic [MAX_FIELDS-1:0] mask, input logic [IDX_W-1:0] from);
        next_t r;
        r = '0;
        for (int i = MAX_FIELDS - 1; i >= 0; i--) begin
            if (mask[i] && (IDX_W'(i) > from)) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic next_t lowest_set(input logic [MAX_FIELDS-1:0] mask);
        next_t r;
        r = '0;
        for (int i = MAX_FIELDS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/field_sequencer_mux.sv
// Combinational field selector: picks field idx out of the packed word and
// zero-extends it to the output width.
module field_mux
    import field_sequencer_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned NUM_FIELDS = 4,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter widths_t     WIDTHS     = '0
) (
    input  logic [IN_WIDTH-1:0]  word,
    input  logic [IDX_W-1:0]     idx,
    output logic [OUT_WIDTH-1:0] field
);

    logic [OUT_WIDTH-1:0] fields [NUM_FIELDS];

    for (genvar n = 0; n < NUM_FIELDS; n++) begin : g_field
        localparam int unsigned OFF = field_offset(n, WIDTHS);
        localparam int unsigned W   = width_of(n, WIDTHS);
        assign fields[n] = OUT_WIDTH'(word[OFF +: W]);
    end

    always_comb begin
        field = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (idx == IDX_W'(i)) field = fields[i];
        end
    end

endmodule

// File: rtl/field_sequencer.sv
// Splits a packed multi-field word into one AXI-Stream beat per enabled
// field, lowest field first, with zero-bubble hand-over between words.
module field_sequencer
    import field_sequencer_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = 32,
    parameter int unsigned NUM_FIELDS   = 4,
    parameter int unsigned FIELD0_WIDTH = 8,
    parameter int unsigned FIELD1_WIDTH = 8,
    parameter int unsigned FIELD2_WIDTH = 8,
    parameter int unsigned FIELD3_WIDTH = 8,
    parameter int unsigned FIELD4_WIDTH = 8,
    parameter int unsigned FIELD5_WIDTH = 8,
    parameter int unsigned FIELD6_WIDTH = 8,
    parameter int unsigned FIELD7_WIDTH = 8,
    parameter int unsigned OUT_WIDTH    = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic [7:0]           s_axis_tuser,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic [2:0]           m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready
);

    localparam widths_t RAW_WIDTHS = {FW_W'(FIELD7_WIDTH), FW_W'(FIELD6_WIDTH),
                                      FW_W'(FIELD5_WIDTH), FW_W'(FIELD4_WIDTH),
                                      FW_W'(FIELD3_WIDTH), FW_W'(FIELD2_WIDTH),
                                      FW_W'(FIELD1_WIDTH), FW_W'(FIELD0_WIDTH)};
    localparam widths_t WIDTHS = resolve_widths(RAW_WIDTHS, IN_WIDTH, NUM_FIELDS);
    localparam logic [MAX_FIELDS-1:0] FIELD_MASK = MAX_FIELDS'((1 << NUM_FIELDS) - 1);

    // Elaboration-time geometry checks.
    if (NUM_FIELDS < 1 || NUM_FIELDS > MAX_FIELDS) begin : g_bad_num
        $error("field_sequencer: NUM_FIELDS must be 1..8");
    end
    if (field_offset(NUM_FIELDS - 1, RAW_WIDTHS) >= IN_WIDTH) begin : g_bad_in
        $error("field_sequencer: fields leave no bits for the last field");
    end
    for (genvar n = 0; n < NUM_FIELDS; n++) begin : g_chk
        if (width_of(n, WIDTHS) == 0 || width_of(n, WIDTHS) > OUT_WIDTH) begin : g_bad_width
            $error("field_sequencer: field width is zero or exceeds OUT_WIDTH");
        end
    end

    state_t                  state_q, state_d;
    logic [IN_WIDTH-1:0]     word_q, word_d;
    logic [MAX_FIELDS-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [MAX_FIELDS-1:0]   mask_in;
    next_t                   nxt;
    next_t                   first;
    logic                    accept;

    assign mask_in = s_axis_tuser & FIELD_MASK;
    assign nxt     = next_set(mask_q, idx_q);
    assign first   = lowest_set(mask_in);

    // Beat outputs come only from registers; tready also depends on m_axis_tready.
    assign m_axis_tvalid = (state_q == EMIT);
    assign m_axis_tlast  = m_axis_tvalid & ~nxt.found;
    assign m_axis_tuser  = idx_q;
    assign s_axis_tready = aresetn & (~m_axis_tvalid | (m_axis_tlast & m_axis_tready));
    assign accept        = s_axis_tvalid & s_axis_tready;

    field_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .NUM_FIELDS(NUM_FIELDS),
        .OUT_WIDTH (OUT_WIDTH),
        .WIDTHS    (WIDTHS)
    ) u_field_mux (
        .word (word_q),
        .idx  (idx_q),
        .field(m_axis_tdata)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            word_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: advance through enabled fields; a newly accepted word overrides.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mask_d  = mask_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: ;
            EMIT: begin
                if (m_axis_tready) begin
                    if (!m_axis_tlast) idx_d   = nxt.idx;
                    else               state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            word_d = s_axis_tdata;
            mask_d = mask_in;
            if (first.found) begin
                idx_d   = first.idx;
                state_d = EMIT;
            end else begin
                state_d = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_field_sequencer.sv
// Directed self-checking bench for field_sequencer with default geometry
// (four 8-bit fields, 16-bit output).
module tb_field_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [7:0]  s_tuser = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic [2:0]  m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [19:0] mon_q[$];   // {tlast, tuser, tdata} of each accepted beat

    always #5 clk = ~clk;

    field_sequencer dut (
        .aclk         (clk),
        .aresetn      (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tuser (m_tuser),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready)
    );

    always @(posedge clk) begin
        if (rst_n && m_tvalid && m_tready) mon_q.push_back({m_tlast, m_tuser, m_tdata});
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({s_tready, m_tvalid, m_tlast, m_tuser, m_tdata} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {s_tready, m_tvalid, m_tlast, m_tuser, m_tdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL after_release got s_tready=%b m_tvalid=%b exp 1/0", s_tready, m_tvalid);
        end
        step();
    endtask

    task automatic test_all_fields;
        logic [15:0] exp_d [4] = '{16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD};
        logic [20:0] exp_b;
        s_tdata = 32'hDDCCBBAA; s_tuser = 8'h0F; s_tvalid = 1'b1; m_tready = 1'b1;
        #1;
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("FAIL all_idle_ready got=%b exp=1", s_tready);
        end
        step();
        s_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_b = {1'b1, (k == 3), 3'(k), exp_d[k]};
            total++;
            if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== exp_b) begin
                bad++;
                $display("FAIL all_beat%0d got=%h exp=%h", k, {m_tvalid, m_tlast, m_tuser, m_tdata}, exp_b);
            end
            total++;
            if (s_tready !== (k == 3)) begin
                bad++;
                $display("FAIL all_s_tready%0d got=%b exp=%b", k, s_tready, (k == 3));
            end
            step();
        end
        total++;
        if (m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL all_end_valid got=%b exp=0", m_tvalid);
        end
    endtask

    task automatic test_sparse_mask;
        mon_q.delete();
        // Upper mask bits are outside NUM_FIELDS and must be ignored.
        s_tdata = 32'hDDCCBBAA; s_tuser = 8'hFA; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b0, 3'd1, 16'h00BB}) begin
            bad++;
            $display("FAIL sparse_beat0 got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b0, 3'd1, 16'h00BB});
        end
        step();
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b1, 3'd3, 16'h00DD}) begin
            bad++;
            $display("FAIL sparse_beat1 got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b1, 3'd3, 16'h00DD});
        end
        step();
        total++;
        if (m_tvalid !== 1'b0 || mon_q.size() != 2) begin
            bad++;
            $display("FAIL sparse_count got valid=%b beats=%0d exp 0/2", m_tvalid, mon_q.size());
        end
    endtask

    task automatic test_zero_mask;
        mon_q.delete();
        s_tdata = 32'hDDCCBBAA; s_tuser = 8'hF0; s_tvalid = 1'b1;
        step();
        s_tdata = 32'h44332211; s_tuser = 8'h01;
        #1;
        total++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            bad++;
            $display("FAIL zero_dropped got valid=%b s_tready=%b exp 0/1", m_tvalid, s_tready);
        end
        step();
        s_tvalid = 1'b0;
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b1, 3'd0, 16'h0011}) begin
            bad++;
            $display("FAIL zero_single got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b1, 3'd0, 16'h0011});
        end
        step();
        total++;
        if (m_tvalid !== 1'b0 || mon_q.size() != 1) begin
            bad++;
            $display("FAIL zero_count got valid=%b beats=%0d exp 0/1", m_tvalid, mon_q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_d [8] = '{16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD,
                                   16'h0011, 16'h0022, 16'h0033, 16'h0044};
        logic [20:0] exp_b;
        m_tready = 1'b1;
        s_tdata = 32'hDDCCBBAA; s_tuser = 8'h0F; s_tvalid = 1'b1;
        step();
        s_tdata = 32'h44332211;
        for (int k = 0; k < 8; k++) begin
            exp_b = {1'b1, (k % 4 == 3), 3'(k % 4), exp_d[k]};
            total++;
            if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== exp_b) begin
                bad++;
                $display("FAIL b2b_beat%0d got=%h exp=%h", k, {m_tvalid, m_tlast, m_tuser, m_tdata}, exp_b);
            end
            if (k < 4) begin
                total++;
                if (s_tready !== (k == 3)) begin
                    bad++;
                    $display("FAIL b2b_s_tready%0d got=%b exp=%b", k, s_tready, (k == 3));
                end
            end
            step();
            if (k == 3) s_tvalid = 1'b0;
        end
        total++;
        if (m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end_valid got=%b exp=0", m_tvalid);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] words [2] = '{32'h44332211, 32'hDDCCBBAA};
        logic [7:0]  masks [2] = '{8'h0D, 8'h06};
        logic [19:0] exp_q [5] = '{{1'b0, 3'd0, 16'h0011}, {1'b0, 3'd2, 16'h0033},
                                   {1'b1, 3'd3, 16'h0044}, {1'b0, 3'd1, 16'h00BB},
                                   {1'b1, 3'd2, 16'h00CC}};
        logic [31:0] rdy_pat = 32'b1011_0010_1101_0011_0110_1001_1100_0101;
        logic [19:0] held = '0;
        logic        held_valid = 1'b0;
        int          wi = 0;
        bit          done = 1'b0;
        mon_q.delete();
        for (int c = 0; c < 60 && !done; c++) begin
            if (held_valid) begin
                total++;
                if ({m_tlast, m_tuser, m_tdata} !== held || m_tvalid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_stall_hold c=%0d got=%h exp=%h", c, {m_tlast, m_tuser, m_tdata}, held);
                end
            end
            m_tready = rdy_pat[c % 32];
            s_tvalid = (wi < 2);
            if (wi < 2) begin
                s_tdata = words[wi];
                s_tuser = masks[wi];
            end
            #1;
            held_valid = m_tvalid & ~m_tready;
            held       = {m_tlast, m_tuser, m_tdata};
            if (s_tvalid && s_tready) wi++;
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            done = (wi == 2) && (mon_q.size() == 5) && !m_tvalid;
        end
        m_tready = 1'b1;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL bp_timeout got beats=%0d exp=5", mon_q.size());
        end
        total++;
        if (mon_q.size() != 5) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=5", mon_q.size());
        end
        for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_beat%0d got=%h exp=%h", i, mon_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_word;
        m_tready = 1'b1;
        s_tdata = 32'hDDCCBBAA; s_tuser = 8'h0F; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        step();
        step();
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b0, 3'd2, 16'h00CC}) begin
            bad++;
            $display("FAIL rst_pre_beat got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b0, 3'd2, 16'h00CC});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_tready, m_tvalid, m_tlast, m_tuser, m_tdata} !== 22'd0) begin
            bad++;
            $display("FAIL rst_async_zero got=%h exp=0", {s_tready, m_tvalid, m_tlast, m_tuser, m_tdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL rst_release got s_tready=%b m_tvalid=%b exp 1/0", s_tready, m_tvalid);
        end
        step();
        s_tdata = 32'h44332211; s_tuser = 8'h0C; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b0, 3'd2, 16'h0033}) begin
            bad++;
            $display("FAIL rst_new_beat0 got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b0, 3'd2, 16'h0033});
        end
        step();
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b1, 3'd3, 16'h0044}) begin
            bad++;
            $display("FAIL rst_new_beat1 got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b1, 3'd3, 16'h0044});
        end
        step();
        total++;
        if (m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL rst_new_end got=%b exp=0", m_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_all_fields();
        test_sparse_mask();
        test_zero_mask();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
